truth_table_test_sequencer: RTL and testbench
=============================================

Name: truth_table_test_sequencer

Overview:
Sequences a multi-channel truth-table test across a bank of per-channel detector instances.
- Fetches stimulus/expected/mask vectors from an external vector RAM and drives stimulus to the DUT.
- Waits a programmable settle time, then strobes the detectors.
- Collects per-channel pass/fail and reports one result per vector to the Ethernet result packer.
- Sits between the command decoder (start/abort/config) and the CH_NUM detector instances.

Parameters:
CH_NUM, 16, number of tested channels / detector instances
VEC_AW, 8, vector RAM address width (max 2^VEC_AW vectors)
SETTLE_W, 16, settle counter width

Ports:
i_clk  in  1  system clock
i_rst  in  1  asynchronous reset, active-low
i_start  in  1  one-cycle start pulse
i_abort  in  1  one-cycle abort pulse
i_vec_last  in  VEC_AW  index of last vector to run
i_settle_cyc  in  SETTLE_W  settle cycles after stimulus change
o_vec_rd  out  1  vector RAM read strobe
o_vec_addr  out  VEC_AW  vector RAM address
i_vec_stim  in  CH_NUM  stimulus word, valid 1 cycle after o_vec_rd
i_vec_expect  in  CH_NUM  expected response, same timing
i_vec_mask  in  CH_NUM  channel enable, same timing
o_stim  out  CH_NUM  stimulus to DUT
i_sample  in  CH_NUM  DUT response (already synchronised upstream)
o_chan_vld  out  CH_NUM  per-channel detector valid
o_truth_data  out  CH_NUM  per-channel match bit to detectors
i_detect_vld  in  CH_NUM  per-channel detector result (1 = pass), combinational
o_res_vld  out  1  one-cycle result pulse per vector
o_res_addr  out  VEC_AW  vector index of result
o_res_fail  out  1  1 = any enabled channel mismatched
o_res_fail_map  out  CH_NUM  per-channel fail bits
o_err_cnt  out  VEC_AW+1  failing vectors this run
o_busy  out  1  run in progress
o_done  out  1  one-cycle run-complete pulse
o_stopped  out  1  run ended early on fail

Behaviour:
- Reset (async, i_rst=0): state IDLE; all outputs 0.
- i_vec_last and i_settle_cyc are latched on accepted start and held for the whole run.
- IDLE:
  - i_start accepted -> clear o_err_cnt, o_stopped, addr=0; go FETCH.
  - i_start while busy is ignored.
- FETCH (1 cyc): o_vec_rd=1, o_vec_addr=addr.
- LOAD (1 cyc): latch stim/expect/mask; o_stim updates at the end of this cycle; load settle counter.
- SETTLE: lasts max(settle,1) cycles. Counter counts down to 1, then go SAMPLE.
- SAMPLE (1 cyc):
  - o_chan_vld = mask.
  - o_truth_data = ~(i_sample ^ expect).
  - Capture fail_map = ~i_detect_vld.
  - o_chan_vld is 0 in all other states; o_truth_data is don't-care outside SAMPLE.
- REPORT (1 cyc):
  - o_res_vld=1, o_res_addr=addr, o_res_fail=|fail_map.
  - o_err_cnt += o_res_fail. It cannot overflow because width is VEC_AW+1.
  - If addr==vec_last -> DONE, else addr+1 -> FETCH.
- DONE (1 cyc): o_done=1, busy drops next cycle; go IDLE.
- Per-vector period: 4+max(settle,1) cycles. First o_res_vld comes 5+max(settle,1) cycles after the start cycle.
- o_busy=1 from the cycle after accepted start through the DONE cycle.
- o_stim holds the last vector after DONE until the next run; o_res_* hold until the next REPORT.
- i_abort, any non-IDLE state:
  - Next state IDLE; o_stim<=0, o_busy<=0.
  - No o_res_vld, no o_done.
  - o_err_cnt holds.
  - Abort wins over a coincident start and over a coincident REPORT/DONE (the result pulse is suppressed).
- Reset mid-run: immediate return to reset values; no partial results.

Optional Feature:
STOP_ON_FAIL_EN:
- Defined: a REPORT with o_res_fail=1 goes to DONE regardless of addr and sets o_stopped=1, which holds until the next start. Remaining vectors are not read.
- Undefined: all vectors run; o_stopped is tied 0.

Test Plan:
1. 4 vectors all matching, settle=3 -> 4 o_res_vld pulses 7 cycles apart, addr 0..3, fail=0, err_cnt=0, o_done one cycle after 4th report.
2. Vector 2: expect=0x00FF, sample=0x00FE, mask=0xFFFF -> res_addr=2, fail=1, fail_map=0x0001, final err_cnt=1.
3. Same mismatch with mask=0xFFFE -> o_chan_vld[0]=0, fail=0, err_cnt=0.
4. vec_last=0, settle=0 -> single result 6 cycles after start, o_done next cycle; repeat start during busy -> ignored, no extra results.
5. Abort during SETTLE of vector 1 -> busy=0 and o_stim=0 next cycle, no o_done; restart -> results from addr 0, err_cnt cleared.
6. STOP_ON_FAIL_EN defined, fail at vector 1 of 4 -> o_done after vector 1 report, o_stopped=1, addresses 2,3 never presented on o_vec_addr with o_vec_rd.

Source files
------------

// File: rtl/truth_table_test_sequencer.sv
// -----------------------------------------------------------------------------
// truth_table_test_sequencer
//
// Walks a truth-table test over CH_NUM channels. For each vector it reads
// stimulus/expected/mask words from an external vector RAM, drives the
// stimulus, waits a programmable settle time, strobes the per-channel
// detectors and reports one pass/fail result per vector.
//
// Configuration macro:
//   STOP_ON_FAIL_EN - when defined, the first failing vector ends the run
//                     early and raises o_stopped; otherwise o_stopped is 0.
//
// Ports:
//   i_clk, i_rst          clock, asynchronous active-low reset
//   i_start, i_abort      one-cycle run control pulses
//   i_vec_last            index of the last vector (latched at start)
//   i_settle_cyc          settle cycles after stimulus change (latched)
//   o_vec_rd, o_vec_addr  vector RAM read; data returns one cycle later on
//   i_vec_stim/expect/mask
//   o_stim                stimulus to the device under test
//   i_sample              device response
//   o_chan_vld            per-channel detector strobe (SAMPLE only)
//   o_truth_data          per-channel match bit (sample equals expected)
//   i_detect_vld          per-channel detector result, 1 = pass
//   o_res_*               per-vector result, held until the next result
//   o_err_cnt             failing vectors in the current run
//   o_busy, o_done        run in progress / run-complete pulse
//   o_stopped             run ended early on a failing vector
//
// Result, done and busy outputs are registered, so each appears one cycle
// after the FSM state that produces it.
// -----------------------------------------------------------------------------
module truth_table_test_sequencer #(
  parameter int CH_NUM   = 16,
  parameter int VEC_AW   = 8,
  parameter int SETTLE_W = 16
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic                i_abort,
  input  logic [VEC_AW-1:0]   i_vec_last,
  input  logic [SETTLE_W-1:0] i_settle_cyc,
  output logic                o_vec_rd,
  output logic [VEC_AW-1:0]   o_vec_addr,
  input  logic [CH_NUM-1:0]   i_vec_stim,
  input  logic [CH_NUM-1:0]   i_vec_expect,
  input  logic [CH_NUM-1:0]   i_vec_mask,
  output logic [CH_NUM-1:0]   o_stim,
  input  logic [CH_NUM-1:0]   i_sample,
  output logic [CH_NUM-1:0]   o_chan_vld,
  output logic [CH_NUM-1:0]   o_truth_data,
  input  logic [CH_NUM-1:0]   i_detect_vld,
  output logic                o_res_vld,
  output logic [VEC_AW-1:0]   o_res_addr,
  output logic                o_res_fail,
  output logic [CH_NUM-1:0]   o_res_fail_map,
  output logic [VEC_AW:0]     o_err_cnt,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_stopped
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_SETTLE, S_SAMPLE, S_REPORT, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [VEC_AW-1:0]   addr_q, vec_last_q;
  logic [SETTLE_W-1:0] settle_q, settle_cnt_q;
  logic [CH_NUM-1:0]   expect_q, mask_q, fail_map_q;

  // Busy stays high through the visible o_done cycle, so gating start with
  // it keeps "start while busy is ignored" true even after the FSM is idle.
  logic start_ok, aborting, rpt_fail, stop_now;
  assign start_ok = (state_q == S_IDLE) && i_start && !o_busy;
  assign aborting = (state_q != S_IDLE) && i_abort;
  assign rpt_fail = |fail_map_q;

`ifdef STOP_ON_FAIL_EN
  assign stop_now = rpt_fail;
`else
  assign stop_now = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch forms.
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (start_ok) state_d = S_FETCH;
      S_FETCH:  state_d = S_LOAD;
      S_LOAD:   state_d = S_SETTLE;
      S_SETTLE: if (settle_cnt_q == SETTLE_W'(1)) state_d = S_SAMPLE;
      S_SAMPLE: state_d = S_REPORT;
      S_REPORT: state_d = (stop_now || addr_q == vec_last_q) ? S_DONE : S_FETCH;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (aborting) state_d = S_IDLE;
  end

  // ---------------------------------------------------------------------------
  // State register and datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q        <= S_IDLE;
      addr_q         <= '0;
      vec_last_q     <= '0;
      settle_q       <= '0;
      settle_cnt_q   <= '0;
      expect_q       <= '0;
      mask_q         <= '0;
      fail_map_q     <= '0;
      o_stim         <= '0;
      o_res_vld      <= 1'b0;
      o_res_addr     <= '0;
      o_res_fail     <= 1'b0;
      o_res_fail_map <= '0;
      o_err_cnt      <= '0;
      o_busy         <= 1'b0;
      o_done         <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout so every register samples pre-edge values.
      state_q   <= state_d;
      o_res_vld <= 1'b0;
      o_done    <= 1'b0;

      if (o_done) o_busy <= 1'b0;

      if (start_ok) begin
        o_busy     <= 1'b1;
        o_err_cnt  <= '0;
        addr_q     <= '0;
        vec_last_q <= i_vec_last;
        settle_q   <= i_settle_cyc;
      end

      unique case (state_q)
        S_LOAD: begin
          o_stim       <= i_vec_stim;
          expect_q     <= i_vec_expect;
          mask_q       <= i_vec_mask;
          // A zero setting still gives one settle cycle.
          settle_cnt_q <= (settle_q == '0) ? SETTLE_W'(1) : settle_q;
        end
        S_SETTLE: settle_cnt_q <= settle_cnt_q - SETTLE_W'(1);
        // Masked channels can never fail, whatever the detector reports.
        S_SAMPLE: fail_map_q <= ~i_detect_vld & mask_q;
        S_REPORT: if (!i_abort) begin
          o_res_vld      <= 1'b1;
          o_res_addr     <= addr_q;
          o_res_fail     <= rpt_fail;
          o_res_fail_map <= fail_map_q;
          o_err_cnt      <= o_err_cnt + (VEC_AW+1)'(rpt_fail);
          if (state_d == S_FETCH) addr_q <= addr_q + VEC_AW'(1);
        end
        S_DONE: if (!i_abort) o_done <= 1'b1;
        default: ;
      endcase

      if (aborting) begin
        o_stim <= '0;
        o_busy <= 1'b0;
      end
    end
  end

`ifdef STOP_ON_FAIL_EN
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst)                                            o_stopped <= 1'b0;
    else if (start_ok)                                     o_stopped <= 1'b0;
    else if (state_q == S_REPORT && !i_abort && rpt_fail)  o_stopped <= 1'b1;
  end
`else
  assign o_stopped = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Combinational outputs
  // ---------------------------------------------------------------------------
  assign o_vec_rd     = (state_q == S_FETCH);
  assign o_vec_addr   = addr_q;
  assign o_chan_vld   = (state_q == S_SAMPLE) ? mask_q : '0;
  assign o_truth_data = (state_q == S_SAMPLE) ? ~(i_sample ^ expect_q) : '0;

endmodule

// File: tb/tb_truth_table_test_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for truth_table_test_sequencer. Provides a vector RAM, a device
// under test whose response is stimulus XOR a flip pattern, and detectors that
// pass when strobed with a match. Expected results and their cycle positions
// come from per-vector arithmetic on the RAM contents.
// -----------------------------------------------------------------------------
module tb_truth_table_test_sequencer;

  localparam int CH = 16;
  localparam int AW = 8;
  localparam int SW = 16;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b0;
  logic          i_start = 1'b0;
  logic          i_abort = 1'b0;
  logic [AW-1:0] i_vec_last = '0;
  logic [SW-1:0] i_settle_cyc = '0;
  logic          o_vec_rd;
  logic [AW-1:0] o_vec_addr;
  logic [CH-1:0] i_vec_stim = '0;
  logic [CH-1:0] i_vec_expect = '0;
  logic [CH-1:0] i_vec_mask = '0;
  logic [CH-1:0] o_stim;
  logic [CH-1:0] i_sample;
  logic [CH-1:0] o_chan_vld;
  logic [CH-1:0] o_truth_data;
  logic [CH-1:0] i_detect_vld;
  logic          o_res_vld;
  logic [AW-1:0] o_res_addr;
  logic          o_res_fail;
  logic [CH-1:0] o_res_fail_map;
  logic [AW:0]   o_err_cnt;
  logic          o_busy;
  logic          o_done;
  logic          o_stopped;

  truth_table_test_sequencer #(.CH_NUM(CH), .VEC_AW(AW), .SETTLE_W(SW)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_abort(i_abort),
    .i_vec_last(i_vec_last), .i_settle_cyc(i_settle_cyc),
    .o_vec_rd(o_vec_rd), .o_vec_addr(o_vec_addr),
    .i_vec_stim(i_vec_stim), .i_vec_expect(i_vec_expect), .i_vec_mask(i_vec_mask),
    .o_stim(o_stim), .i_sample(i_sample),
    .o_chan_vld(o_chan_vld), .o_truth_data(o_truth_data), .i_detect_vld(i_detect_vld),
    .o_res_vld(o_res_vld), .o_res_addr(o_res_addr), .o_res_fail(o_res_fail),
    .o_res_fail_map(o_res_fail_map), .o_err_cnt(o_err_cnt),
    .o_busy(o_busy), .o_done(o_done), .o_stopped(o_stopped)
  );

  always #5 i_clk = ~i_clk;

  // Vector RAM contents and the device-under-test flip pattern.
  logic [CH-1:0] m_stim [256];
  logic [CH-1:0] m_exp  [256];
  logic [CH-1:0] m_mask [256];
  logic [CH-1:0] sample_flip = '0;

  always @(posedge i_clk) begin
    if (o_vec_rd) begin
      i_vec_stim   <= m_stim[o_vec_addr];
      i_vec_expect <= m_exp[o_vec_addr];
      i_vec_mask   <= m_mask[o_vec_addr];
    end
  end

  assign i_sample     = o_stim ^ sample_flip;
  assign i_detect_vld = o_chan_vld & o_truth_data;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fill_match(input int n);
    for (int i = 0; i < n; i++) begin
      m_stim[i] = 16'($urandom());
      m_exp[i]  = m_stim[i];
      m_mask[i] = 16'hFFFF;
    end
    sample_flip = '0;
  endtask

  // One run: start in cycle 0, then check every cycle against the schedule
  // FETCH at 1+v*P, SAMPLE at 3+S+v*P, result visible at 5+S+v*P, done one
  // cycle after the last result (S = max(settle,1), P = 4+S).
  // abort_at > 0 pulses i_abort during that cycle.
  task automatic run(input int last, input int settle, input int abort_at, input bit dup);
    int sp, per, first, n_res, done_t, end_t, err_exp, v;
    bit aborted, live, exp_vld, exp_rd;
    logic [CH-1:0] exp_cv;
    logic [CH-1:0] fm[$];
    sp    = (settle == 0) ? 1 : settle;
    per   = 4 + sp;
    first = 5 + sp;
    n_res = 0;
    for (int i = 0; i <= last; i++) begin
      logic [CH-1:0] f;
      f = ((m_stim[i] ^ sample_flip) ^ m_exp[i]) & m_mask[i];
      fm.push_back(f);
      n_res++;
`ifdef STOP_ON_FAIL_EN
      if (f != '0) break;
`endif
    end
    done_t  = first + (n_res - 1) * per + 1;
    aborted = (abort_at > 0);
    end_t   = aborted ? abort_at + 3 : done_t + 2;
    err_exp = 0;

    @(negedge i_clk);
    i_vec_last   = AW'(last);
    i_settle_cyc = SW'(settle);
    i_start      = 1'b1;

    for (int t = 1; t <= end_t; t++) begin
      @(negedge i_clk);
      live = !(aborted && t > abort_at);

      exp_vld = 1'b0;
      if (live && t >= first && (t - first) % per == 0 && (t - first) / per < n_res) begin
        exp_vld = 1'b1;
        v = (t - first) / per;
        if (fm[v] != '0) err_exp++;
      end
      check("res_vld", 32'(o_res_vld), 32'(exp_vld));
      if (exp_vld) begin
        check("res_addr", 32'(o_res_addr), 32'(v));
        check("res_fail", 32'(o_res_fail), 32'(fm[v] != '0));
        check("res_fail_map", 32'(o_res_fail_map), 32'(fm[v]));
      end
      check("err_cnt", 32'(o_err_cnt), 32'(err_exp));
      check("done", 32'(o_done), 32'(live && t == done_t));
      check("busy", 32'(o_busy), 32'(live && t <= done_t));

      exp_rd = 1'b0;
      if (live && (t - 1) % per == 0 && (t - 1) / per < n_res) begin
        exp_rd = 1'b1;
        check("vec_addr", 32'(o_vec_addr), 32'((t - 1) / per));
      end
      check("vec_rd", 32'(o_vec_rd), 32'(exp_rd));

      exp_cv = '0;
      if (live && t >= first - 2 && (t - first + 2) % per == 0 && (t - first + 2) / per < n_res) begin
        v = (t - first + 2) / per;
        exp_cv = m_mask[v];
        check("stim", 32'(o_stim), 32'(m_stim[v]));
      end
      check("chan_vld", 32'(o_chan_vld), 32'(exp_cv));
      if (!live) check("stim_abort", 32'(o_stim), 32'h0);

      i_start = dup && (t == 3);
      i_abort = aborted && (t == abort_at);
    end
    i_start = 1'b0;
    i_abort = 1'b0;
`ifdef STOP_ON_FAIL_EN
    check("stopped", 32'(o_stopped), 32'(!aborted && fm[n_res - 1] != '0));
`else
    check("stopped", 32'(o_stopped), 32'h0);
`endif
  endtask

  initial begin
    // Reset values
    #1;
    check("rst_busy", 32'(o_busy), 32'h0);
    check("rst_res_vld", 32'(o_res_vld), 32'h0);
    check("rst_done", 32'(o_done), 32'h0);
    check("rst_err_cnt", 32'(o_err_cnt), 32'h0);
    check("rst_stim", 32'(o_stim), 32'h0);
    check("rst_vec_rd", 32'(o_vec_rd), 32'h0);
    check("rst_chan_vld", 32'(o_chan_vld), 32'h0);
    check("rst_stopped", 32'(o_stopped), 32'h0);
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b1;

    // 1: four matching vectors, settle 3
    fill_match(4);
    run(3, 3, 0, 1'b0);

    // 2: single-bit mismatch on vector 2, all channels enabled
    m_stim[2] = 16'h00FE;
    m_exp[2]  = 16'h00FF;
    run(3, 3, 0, 1'b0);

    // 3: same mismatch with the failing channel masked off
    m_mask[2] = 16'hFFFE;
    run(3, 3, 0, 1'b0);

    // 4: one vector, zero settle, repeated start while busy
    run(0, 0, 0, 1'b1);

    // 5: abort during SETTLE of vector 1, then a full restart
    fill_match(4);
    run(3, 3, 3 + 7, 1'b0);
    run(3, 3, 0, 1'b0);

    // 6: fail at vector 1 of 4
    fill_match(4);
    m_exp[1] = m_stim[1] ^ 16'h0100;
    run(3, 2, 0, 1'b0);

    // Randomised runs
    for (int r = 0; r < 6; r++) begin
      int last, settle;
      last   = int'($urandom_range(0, 7));
      settle = int'($urandom_range(0, 4));
      for (int i = 0; i <= last; i++) begin
        m_stim[i] = 16'($urandom());
        m_exp[i]  = m_stim[i];
        if ($urandom_range(0, 2) == 0) m_exp[i] = m_exp[i] ^ (16'h1 << $urandom_range(0, 15));
        m_mask[i] = 16'($urandom());
      end
      sample_flip = ($urandom_range(0, 3) == 0) ? (16'h1 << $urandom_range(0, 15)) : 16'h0;
      run(last, settle, 0, 1'b0);
    end

    // Reset in the middle of a run
    fill_match(4);
    @(negedge i_clk);
    i_vec_last   = 8'd3;
    i_settle_cyc = 16'd3;
    i_start      = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    repeat (6) @(negedge i_clk);
    #2 i_rst = 1'b0;
    #1;
    check("midrst_busy", 32'(o_busy), 32'h0);
    check("midrst_stim", 32'(o_stim), 32'h0);
    check("midrst_chan_vld", 32'(o_chan_vld), 32'h0);
    check("midrst_vec_rd", 32'(o_vec_rd), 32'h0);
    @(negedge i_clk);
    i_rst = 1'b1;
    repeat (12) begin
      @(negedge i_clk);
      check("midrst_no_res", 32'(o_res_vld), 32'h0);
    end
    run(1, 1, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
